// File: rtl/stride_prefetch_engine_pkg.sv
// Shared types for the stride prefetcher: RPT entry layout, entry/update FSM encodings,
// and the per-entry confidence transition function.
package rpt_pkg;

    // Entry fields are sized for the widest supported address; users slice to ADDR_W.
    localparam int unsigned RPT_MAX_W = 64;

    typedef enum logic [1:0] {
        INIT   = 2'b00,
        TRANS  = 2'b01,
        STEADY = 2'b10,
        NOPRED = 2'b11
    } rpt_state_e;

    typedef enum logic [1:0] {
        IDLE,
        UPDATE,
        WAIT
    } upd_state_e;

    typedef struct packed {
        logic                 valid;
        logic [RPT_MAX_W-1:0] tag;
        logic [RPT_MAX_W-1:0] prev_addr;
        logic [RPT_MAX_W-1:0] stride;
        rpt_state_e           state;
    } rpt_entry_t;

    function automatic rpt_state_e rpt_next_state(input rpt_state_e s, input logic c);
        rpt_state_e n;
        unique case (s)
            INIT:    n = c ? STEADY : TRANS;
            TRANS:   n = c ? STEADY : NOPRED;
            STEADY:  n = c ? STEADY : INIT;
            NOPRED:  n = c ? TRANS  : NOPRED;
            default: n = INIT;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/stride_prefetch_engine_if.sv
// Prefetch request channel from the engine (master) to L2 (slave).
interface stride_prefetch_engine_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              pf_valid;
    logic [ADDR_W-1:0] pf_addr;
    logic              pf_ready;

    modport master (output pf_valid, output pf_addr, input pf_ready);
    modport slave  (input pf_valid, input pf_addr, output pf_ready);
endinterface

// File: rtl/stride_prefetch_engine_orb_fifo.sv
// Outstanding request buffer: circular FIFO with a combinational membership query
// used to suppress duplicate prefetches.
module prefetch_orb_fifo #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic              pop,
    output logic              push_acc,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] head,
    input  logic [ADDR_W-1:0] query,
    output logic              contains
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic              rd_en;

    always_comb begin
        full     = (count == CW'(DEPTH));
        empty    = (count == '0);
        rd_en    = pop && !empty;
        // A full buffer still takes a push when the head leaves in the same cycle.
        push_acc = push && (!full || rd_en);
        head     = empty ? '0 : mem[rd_ptr];
    end

    always_comb begin
        logic [PW-1:0] offs;
        contains = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offs = PW'(i) - rd_ptr;
            if ((CW'(offs) < count) && (mem[i] == query))
                contains = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_acc) begin
                mem[wr_ptr] <= push_addr;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_acc) - CW'(rd_en);
        end
    end
endmodule

// File: rtl/stride_prefetch_engine.sv
// PC-indexed stride prefetcher: direct-mapped RPT trained on data misses, looked up per fetched PC.
// Optional RPT_LOOKAHEAD_EN: predict prev_addr + 2*stride instead of prev_addr + stride.
module stride_prefetch_engine
    import rpt_pkg::*;
#(
    parameter int unsigned ENTRIES   = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned IDX_LSB   = 2,
    parameter int unsigned ORB_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        if_pc,
    input  logic                     new_instr,
    input  logic                     miss_valid,
    input  logic [ADDR_W-1:0]        miss_addr,
    input  logic [ADDR_W-1:0]        miss_pc,
    stride_prefetch_engine_if.master pf,
    output logic                     busy
);
    localparam int unsigned IW      = $clog2(ENTRIES);
    localparam int unsigned TAG_LSB = IDX_LSB + IW;
    localparam int unsigned TAG_W   = ADDR_W - TAG_LSB;

    upd_state_e        st, st_nxt;
    logic              cap_en, tbl_we;
    logic [ADDR_W-1:0] cap_pc, cap_addr;

    rpt_entry_t        tbl [ENTRIES];

    // ---------------- update FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) st <= IDLE;
        else     st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        unique case (st)
            IDLE:    if (miss_valid) st_nxt = UPDATE;
            UPDATE:  st_nxt = WAIT;
            WAIT:    if (!miss_valid) st_nxt = IDLE;
            default: st_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy   = (st == UPDATE);
        cap_en = (st == IDLE) && miss_valid;
        tbl_we = (st == UPDATE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_pc   <= '0;
            cap_addr <= '0;
        end else if (cap_en) begin
            cap_pc   <= miss_pc;
            cap_addr <= miss_addr;
        end
    end

    // ---------------- training ----------------
    logic [IW-1:0]     u_idx;
    rpt_entry_t        u_old, u_entry;
    logic [ADDR_W-1:0] u_prev, u_stride, u_pred;
    logic              u_hit, u_c;

    always_comb begin
        u_idx    = cap_pc[IDX_LSB +: IW];
        u_old    = tbl[u_idx];
        u_prev   = u_old.prev_addr[ADDR_W-1:0];
        u_stride = u_old.stride[ADDR_W-1:0];
        u_pred   = u_prev + u_stride;
        u_hit    = u_old.valid && (u_old.tag[TAG_W-1:0] == cap_pc[ADDR_W-1:TAG_LSB]);
        u_c      = (cap_addr == u_pred);

        u_entry           = '0;
        u_entry.valid     = 1'b1;
        u_entry.tag       = RPT_MAX_W'(cap_pc[ADDR_W-1:TAG_LSB]);
        u_entry.prev_addr = RPT_MAX_W'(cap_addr);
        if (!u_hit) begin
            u_entry.stride = '0;
            u_entry.state  = INIT;
        end else begin
            u_entry.state = rpt_next_state(u_old.state, u_c);
            // A mispredict relearns the stride except from STEADY, which gets one grace miss.
            if (!u_c && (u_old.state != STEADY))
                u_entry.stride = RPT_MAX_W'(cap_addr - u_prev);
            else
                u_entry.stride = u_old.stride;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++)
                tbl[i] <= '0;
        end else if (tbl_we) begin
            tbl[u_idx] <= u_entry;
        end
    end

    // ---------------- lookup ----------------
    logic [IW-1:0]     lk_idx;
    rpt_entry_t        lk_e;
    logic [ADDR_W-1:0] lk_prev, lk_stride, lk_cand;
    logic              lk_hit, push_req, push_acc, pop;
    logic              orb_full, orb_empty, orb_has;
    logic [ADDR_W-1:0] orb_head;
    logic [ADDR_W-1:0] last_push;
    logic              last_vld;

    always_comb begin
        lk_idx    = if_pc[IDX_LSB +: IW];
        lk_e      = tbl[lk_idx];
        lk_prev   = lk_e.prev_addr[ADDR_W-1:0];
        lk_stride = lk_e.stride[ADDR_W-1:0];
        lk_hit    = lk_e.valid && (lk_e.tag[TAG_W-1:0] == if_pc[ADDR_W-1:TAG_LSB]);
`ifdef RPT_LOOKAHEAD_EN
        lk_cand   = lk_prev + (lk_stride << 1);
`else
        lk_cand   = lk_prev + lk_stride;
`endif
        push_req  = new_instr && !busy && lk_hit && (lk_e.state == STEADY) &&
                    (lk_stride != '0) && !orb_has && !(last_vld && (lk_cand == last_push));
        pop       = pf.pf_valid && pf.pf_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_push <= '0;
            last_vld  <= 1'b0;
        end else if (push_acc) begin
            last_push <= lk_cand;
            last_vld  <= 1'b1;
        end
    end

    prefetch_orb_fifo #(
        .ADDR_W (ADDR_W),
        .DEPTH  (ORB_DEPTH)
    ) u_orb (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req),
        .push_addr (lk_cand),
        .pop       (pop),
        .push_acc  (push_acc),
        .full      (orb_full),
        .empty     (orb_empty),
        .head      (orb_head),
        .query     (lk_cand),
        .contains  (orb_has)
    );

    always_comb begin
        pf.pf_valid = !orb_empty;
        pf.pf_addr  = orb_head;
    end
endmodule
